// File: rtl/instruction_word_selector_pkg.sv
// Shared constants for selecting one instruction word out of a cache block.
// The select is the block-offset field addr[3:2] of the fetch address.
package instruction_word_selector_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 4;
  localparam int SEL_W     = $clog2(NUM_WORDS);

  // Position of the word-select field inside the CPU address.
  localparam int OFFSET_LSB = 2;
  localparam int OFFSET_MSB = OFFSET_LSB + SEL_W - 1;

  localparam logic [SEL_W-1:0] WORD0 = 2'd0;
  localparam logic [SEL_W-1:0] WORD1 = 2'd1;
  localparam logic [SEL_W-1:0] WORD2 = 2'd2;
  localparam logic [SEL_W-1:0] WORD3 = 2'd3;

  function automatic logic is_last_word(input logic [SEL_W-1:0] sel);
    return (sel == WORD3);
  endfunction

endpackage

// File: rtl/instruction_word_selector_if.sv
// Bus between the cache data array / CPU and the word selector.
// No back-pressure: OUT_VALID is a one-cycle pulse and the consumer must take OUT_REG then.
interface instruction_word_selector_if;
  import instruction_word_selector_pkg::*;

  logic [WORD_W-1:0] IN0;
  logic [WORD_W-1:0] IN1;
  logic [WORD_W-1:0] IN2;
  logic [WORD_W-1:0] IN3;
  logic [SEL_W-1:0]  SELECT;
  logic              LOAD;
  logic [WORD_W-1:0] OUT;
  logic [WORD_W-1:0] OUT_REG;
  logic              OUT_VALID;
  logic              OUT_LAST;

  modport master (
    output IN0, IN1, IN2, IN3, SELECT, LOAD,
    input  OUT, OUT_REG, OUT_VALID, OUT_LAST
  );

  modport slave (
    input  IN0, IN1, IN2, IN3, SELECT, LOAD,
    output OUT, OUT_REG, OUT_VALID, OUT_LAST
  );

endinterface

// File: rtl/instruction_word_selector_word_mux4.sv
// Pure combinational 4:1 word mux; an unknown select yields all-X in simulation.
module word_mux4
  import instruction_word_selector_pkg::*;
(
  input  logic [WORD_W-1:0] in0_i,
  input  logic [WORD_W-1:0] in1_i,
  input  logic [WORD_W-1:0] in2_i,
  input  logic [WORD_W-1:0] in3_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [WORD_W-1:0] out_o
);

  always_comb begin
    out_o = 'x;
    case (sel_i)
      WORD0:   out_o = in0_i;
      WORD1:   out_o = in1_i;
      WORD2:   out_o = in2_i;
      WORD3:   out_o = in3_i;
      default: out_o = 'x;
    endcase
  end

endmodule

// File: rtl/instruction_word_selector.sv
// Instruction word selector: zero-latency selected word for the hit path plus a
// registered copy with a one-cycle valid pulse and a last-word flag.
module instruction_word_selector
  import instruction_word_selector_pkg::*;
(
  input  logic                        CLOCK,
  input  logic                        RESET_N,
  instruction_word_selector_if.slave  bus
);

  logic [WORD_W-1:0] sel_word;
  logic [WORD_W-1:0] out_reg_q, out_reg_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  // One mux feeds both the combinational output and the capture register.
  word_mux4 u_word_mux4 (
    .in0_i (bus.IN0),
    .in1_i (bus.IN1),
    .in2_i (bus.IN2),
    .in3_i (bus.IN3),
    .sel_i (bus.SELECT),
    .out_o (sel_word)
  );

  always_comb begin
    out_reg_d   = out_reg_q;
    out_last_d  = out_last_q;
    out_valid_d = bus.LOAD;
    if (bus.LOAD) begin
      out_reg_d  = sel_word;
      out_last_d = is_last_word(bus.SELECT);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_reg_q   <= out_reg_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.OUT       = sel_word;
  assign bus.OUT_REG   = out_reg_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_instruction_word_selector.sv
// Directed bench for instruction_word_selector with a capture scoreboard.
module tb_instruction_word_selector;
  import instruction_word_selector_pkg::*;

  localparam int W = WORD_W + 1;

  logic CLOCK;
  logic RESET_N;
  instruction_word_selector_if bus ();

  instruction_word_selector dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  // clock / reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]      exp_q[$];
  logic              m_valid;
  logic [WORD_W-1:0] m_reg;
  logic              m_last;

  task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] pick(input logic [SEL_W-1:0] s);
    logic [WORD_W-1:0] words [NUM_WORDS];
    words[0] = bus.IN0;
    words[1] = bus.IN1;
    words[2] = bus.IN2;
    words[3] = bus.IN3;
    return words[s];
  endfunction

  // driver + scoreboard: record expectation before the edge, check after it
  task automatic tick(input string tag);
    logic [W-1:0] e;
    if (RESET_N && bus.LOAD) begin
      exp_q.push_back({(bus.SELECT == 2'd3), pick(bus.SELECT)});
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    @(posedge CLOCK);
    #1;
    chk({tag, ".valid"}, {31'd0, bus.OUT_VALID}, {31'd0, m_valid});
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".queue_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        m_reg  = e[WORD_W-1:0];
        m_last = e[WORD_W];
      end
    end
    chk({tag, ".reg"}, bus.OUT_REG, m_reg);
    chk({tag, ".last"}, {31'd0, bus.OUT_LAST}, {31'd0, m_last});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid = 1'b0;
    m_reg   = '0;
    m_last  = 1'b0;
  endtask

  initial begin
    RESET_N    = 1'b1;
    bus.LOAD   = 1'b0;
    bus.SELECT = 2'd0;
    bus.IN0 = 32'h0000_0011;
    bus.IN1 = 32'h0000_0022;
    bus.IN2 = 32'h0000_0033;
    bus.IN3 = 32'h0000_0044;
    model_reset();
    #1 RESET_N = 1'b0;
    #1;
    chk("rst.reg",   bus.OUT_REG, 32'd0);
    chk("rst.valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("rst.last",  {31'd0, bus.OUT_LAST}, 32'd0);
    chk("rst.out",   bus.OUT, 32'h11);
    RESET_N = 1'b1;

    // combinational sweep
    for (int s = 0; s < NUM_WORDS; s++) begin
      bus.SELECT = s[1:0];
      #1;
      chk($sformatf("comb.sel%0d", s), bus.OUT, 32'h11 * (s + 1));
    end

    bus.SELECT = 2'd2;
    bus.IN2 = 32'hDEAD_BEEF;
    #1 chk("comb.follow_in2", bus.OUT, 32'hDEAD_BEEF);
    bus.IN1 = 32'h1234_5678;
    #1 chk("comb.ignore_in1", bus.OUT, 32'hDEAD_BEEF);
    bus.IN1 = 32'h0000_0022;
    bus.IN2 = 32'h0000_0033;

    // single load of the last word, then idle
    @(negedge CLOCK);
    bus.LOAD = 1'b1;
    bus.SELECT = 2'd3;
    bus.IN3 = 32'hCAFE_F00D;
    tick("load3");
    chk("load3.value", bus.OUT_REG, 32'hCAFE_F00D);
    bus.LOAD = 1'b0;
    tick("idle1");

    // back-to-back loads
    bus.LOAD = 1'b1;
    for (int s = 0; s < 3; s++) begin
      bus.SELECT = s[1:0];
      tick($sformatf("b2b%0d", s));
      chk($sformatf("b2b%0d.value", s), bus.OUT_REG, 32'h11 * (s + 1));
    end
    bus.LOAD = 1'b0;
    tick("idle2");

    // asynchronous reset while a capture is visible
    bus.LOAD = 1'b1;
    bus.SELECT = 2'd1;
    tick("pre_rst");
    #3 RESET_N = 1'b0;
    model_reset();
    #1;
    chk("arst.reg",   bus.OUT_REG, 32'd0);
    chk("arst.valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("arst.last",  {31'd0, bus.OUT_LAST}, 32'd0);
    chk("arst.out",   bus.OUT, 32'h22);
    bus.SELECT = 2'd2;
    tick("in_rst");

    // load held high across reset release
    bus.SELECT = 2'd3;
    RESET_N = 1'b1;
    tick("rel_load");
    bus.LOAD = 1'b0;
    tick("idle3");

    // random loads
    for (int i = 0; i < 20; i++) begin
      bus.LOAD   = 1'($urandom_range(0, 1));
      bus.SELECT = 2'($urandom_range(0, 3));
      bus.IN0 = $urandom;
      bus.IN1 = $urandom;
      bus.IN2 = $urandom;
      bus.IN3 = $urandom;
      tick($sformatf("rnd%0d", i));
    end

    // unknown select: combinational output goes X, registers hold
    bus.LOAD = 1'b0;
    bus.SELECT = 2'bx1;
    #1;
    if ($isunknown(bus.SELECT)) chk("xsel.out", bus.OUT, 32'hxxxx_xxxx);
    tick("xsel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_word_selector.md
Name: instruction_word_selector

Overview:
- Picks one 32-bit instruction word out of a 128-bit instruction-cache block, using block-offset bits [3:2] of the CPU address.
- Sits between the instruction cache data array and the CPU instruction bus.
- Provides a zero-latency combinational output for the cache-hit path.
- Provides a registered copy with a valid flag for pipelined consumers.

Parameters:
- WORD_W, 32, width of one instruction word and of each input lane.
- NUM_WORDS, 4, words per cache block; fixed at 4 in this revision, other values unsupported.
- SEL_W, 2, select width (log2 of NUM_WORDS); derived, not overridden.

Ports:
- CLOCK  in  1  system clock, rising-edge active.
- RESET_N  in  1  asynchronous, active-low reset.
- IN0  in  WORD_W  block word 0 (block bits [31:0]).
- IN1  in  WORD_W  block word 1 (block bits [63:32]).
- IN2  in  WORD_W  block word 2 (block bits [95:64]).
- IN3  in  WORD_W  block word 3 (block bits [127:96]).
- SELECT  in  SEL_W  word select, equal to address offset bits [3:2].
- LOAD  in  1  capture request for the registered output.
- OUT  out  WORD_W  combinational selected word.
- OUT_REG  out  WORD_W  registered selected word.
- OUT_VALID  out  1  OUT_REG holds a word captured on the previous edge.
- OUT_LAST  out  1  registered flag: the captured word was word 3 (last word of the block).

Behaviour:
- Combinational path:
  - OUT = IN0/IN1/IN2/IN3 for SELECT = 0/1/2/3.
  - Zero clock latency; no state involved.
  - Fully decoded, no latch inferred.
  - SELECT containing X/Z drives OUT to all-X in simulation.
  - Any input change propagates to OUT in the same delta; no explicit delays in RTL.
- Registered path, on each rising CLOCK edge with RESET_N high:
  - LOAD=1: OUT_REG <= selected word, OUT_LAST <= (SELECT==3), OUT_VALID <= 1.
  - LOAD=0: OUT_REG and OUT_LAST hold, OUT_VALID <= 0. OUT_VALID is a one-cycle pulse per load.
  - Back-to-back LOADs: each cycle captures that cycle's SELECT and inputs; OUT_VALID stays 1.
  - Latency: exactly one cycle from the LOAD edge to OUT_REG/OUT_VALID.
- Reset:
  - RESET_N low immediately (asynchronously) forces OUT_REG=0, OUT_VALID=0, OUT_LAST=0, independent of CLOCK.
  - OUT is not reset; it always reflects the inputs.
  - Reset asserted mid-stream discards the pending capture.
  - The first LOAD edge after RESET_N deasserts behaves normally.
  - LOAD held high across reset release: capture occurs on the first edge with RESET_N high.
- Simultaneous input change and clock edge: the capture uses input values present before the edge (standard setup semantics).
- No handshake back-pressure: the consumer must sample OUT_REG while OUT_VALID=1.

Decomposition:
- Shared package holds:
  - WORD_W, NUM_WORDS, SEL_W constants.
  - Word index constants WORD0..WORD3 (2'd0..2'd3).
  - The block-offset bit position (offset[3:2]) used by the cache.
- One natural sub-module: word_mux4, the pure combinational 4:1 WORD_W mux.
  - Instantiated once and shared by OUT and the capture register.
- The register stage stays in the top module.

Test Plan:
- Distinct words: IN0=0x0000_0011, IN1=0x0000_0022, IN2=0x0000_0033, IN3=0x0000_0044. Sweep SELECT 0..3 -> OUT=0x11, 0x22, 0x33, 0x44 in the same timestep.
- Input change with SELECT=2: change IN2 to 0xDEAD_BEEF -> OUT follows immediately. Change IN1 -> OUT unchanged.
- LOAD=1, SELECT=3, IN3=0xCAFE_F00D for one edge -> next cycle OUT_REG=0xCAFEF00D, OUT_VALID=1, OUT_LAST=1. Following cycle with LOAD=0 -> OUT_VALID=0, OUT_REG held.
- Back-to-back LOADs with SELECT 0, 1, 2 over three edges -> OUT_REG sequence 0x11, 0x22, 0x33, OUT_VALID continuously 1, OUT_LAST=0.
- Assert RESET_N=0 between clock edges while OUT_VALID=1 -> OUT_REG=0, OUT_VALID=0, OUT_LAST=0 immediately. OUT still equals the selected input.
- SELECT=2'bx1 in simulation -> OUT is all-X. Registered outputs are unaffected while LOAD=0.
